// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 sequencer: states, opcodes and
// the datapath select fields it drives.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b100;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b001;

    localparam logic [1:0] PCSRC_PC4  = 2'b00;
    localparam logic [1:0] PCSRC_IMM  = 2'b01;
    localparam logic [1:0] PCSRC_JALR = 2'b10;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Only add/slt/or/and forms are implemented for R and I arithmetic.
    function automatic logic arith_funct3_ok(input logic [2:0] funct3);
        logic ok;
        case (funct3)
            3'b000, 3'b010, 3'b110, 3'b111: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ctrl_alu_dec.sv
// Combinational opcode/funct3/funct7 to ALU operation decode, with a flag
// marking instructions the sequencer can execute.
module ctrl_alu_dec
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    // Opcode class selects the ALU operation and legality
    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        case (opcode)
            OP_LW, OP_SW: begin
                alu_ctrl = ALU_ADD;
                legal    = 1'b1;
            end
            OP_BR: begin
                alu_ctrl = ALU_SUB;
                legal    = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            OP_R, OP_I: begin
                legal = arith_funct3_ok(funct3);
                case (funct3)
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b111:  alu_ctrl = ALU_AND;
                    // Only register-register forms can subtract; addi ignores bit 30.
                    default: alu_ctrl = (funct7_5 && opcode[5]) ? ALU_SUB : ALU_ADD;
                endcase
            end
            OP_LUI, OP_JAL, OP_JALR: begin
                alu_ctrl = ALU_PASSB;
                legal    = 1'b1;
            end
            default: begin
                alu_ctrl = ALU_ADD;
                legal    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Optional performance counters are enabled with MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        eq,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [2:0]  alu_ctrl,
    output logic        alu_src,
    output logic [2:0]  imm_src,
    output logic [1:0]  result_src,
    output logic        reg_write,
    output logic        illegal,
    output logic [2:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instr_cnt
`endif
);

    state_t      state_r;
    state_t      next_state_s;
    logic        illegal_r;
    logic [6:0]  opcode_s;
    logic [2:0]  dec_alu_s;
    logic        legal_s;
    logic        mem_req_s, mem_we_s, ir_write_s, pc_write_s;
    logic [1:0]  pc_src_s, result_src_s;
    logic [2:0]  alu_ctrl_s, imm_src_s;
    logic        alu_src_s, reg_write_s;
    logic        unused_s;

    assign opcode_s = instr[6:0];
    assign unused_s = ^{instr[31], instr[29:15], instr[11:7]};

    ctrl_alu_dec u_alu_dec (
        .opcode   (opcode_s),
        .funct3   (instr[14:12]),
        .funct7_5 (instr[30]),
        .alu_ctrl (dec_alu_s),
        .legal    (legal_s)
    );

    // State register and sticky illegal flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_FETCH;
            illegal_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == ST_TRAP) begin
                illegal_r <= 1'b1;
            end
        end
    end

    // Next-state and per-state datapath controls
    always_comb begin
        next_state_s = state_r;
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_src_s     = PCSRC_PC4;
        alu_ctrl_s   = ALU_ADD;
        alu_src_s    = 1'b0;
        imm_src_s    = IMM_I;
        result_src_s = RES_ALU;
        reg_write_s  = 1'b0;
        case (state_r)
            ST_FETCH: begin
                mem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_write_s   = 1'b1;
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                next_state_s = legal_s ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                alu_ctrl_s   = dec_alu_s;
                next_state_s = ST_WB;
                case (opcode_s)
                    OP_LW: begin
                        alu_src_s    = 1'b1;
                        imm_src_s    = IMM_I;
                        next_state_s = ST_MEM;
                    end
                    OP_SW: begin
                        alu_src_s    = 1'b1;
                        imm_src_s    = IMM_S;
                        next_state_s = ST_MEM;
                    end
                    OP_BR: begin
                        imm_src_s  = IMM_B;
                        pc_write_s = 1'b1;
                        // funct3[0] distinguishes bne from beq
                        pc_src_s     = (eq ^ instr[12]) ? PCSRC_IMM : PCSRC_PC4;
                        next_state_s = ST_FETCH;
                    end
                    OP_R, OP_I: begin
                        alu_src_s = ~instr[5];
                        imm_src_s = IMM_I;
                    end
                    OP_LUI: begin
                        alu_src_s = 1'b1;
                        imm_src_s = IMM_U;
                    end
                    OP_JAL:  imm_src_s = IMM_J;
                    OP_JALR: imm_src_s = IMM_I;
                    default: next_state_s = ST_TRAP;
                endcase
            end
            ST_MEM: begin
                mem_req_s = 1'b1;
                mem_we_s  = (opcode_s == OP_SW);
                if (mem_ready) begin
                    if (opcode_s == OP_SW) begin
                        pc_write_s   = 1'b1;
                        pc_src_s     = PCSRC_PC4;
                        next_state_s = ST_FETCH;
                    end else begin
                        next_state_s = ST_WB;
                    end
                end else begin
                    next_state_s = ST_MEM;
                end
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                pc_write_s   = 1'b1;
                next_state_s = ST_FETCH;
                case (opcode_s)
                    OP_LW:   result_src_s = RES_MEM;
                    OP_JAL: begin
                        result_src_s = RES_PC4;
                        pc_src_s     = PCSRC_IMM;
                    end
                    OP_JALR: begin
                        result_src_s = RES_PC4;
                        pc_src_s     = PCSRC_JALR;
                    end
                    default: result_src_s = RES_ALU;
                endcase
            end
            ST_TRAP: next_state_s = ST_TRAP;
            default: next_state_s = ST_TRAP;
        endcase
    end

    // Reset forces every output low in the same cycle, including an open mem_req.
    assign mem_req    = rst_n & mem_req_s;
    assign mem_we     = rst_n & mem_we_s;
    assign ir_write   = rst_n & ir_write_s;
    assign pc_write   = rst_n & pc_write_s;
    assign pc_src     = rst_n ? pc_src_s : 2'b00;
    assign alu_ctrl   = rst_n ? alu_ctrl_s : 3'b000;
    assign alu_src    = rst_n & alu_src_s;
    assign imm_src    = rst_n ? imm_src_s : 3'b000;
    assign result_src = rst_n ? result_src_s : 2'b00;
    assign reg_write  = rst_n & reg_write_s;
    assign illegal    = rst_n & illegal_r;
    assign state      = rst_n ? state_r : 3'b000;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] cycle_cnt_r;
    logic [CNT_WIDTH-1:0] instr_cnt_r;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Free-running cycle and retired-instruction counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt_r <= '0;
            instr_cnt_r <= '0;
        end else begin
            if (state_r != ST_TRAP) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
            end
            if (pc_write_s) begin
                instr_cnt_r <= instr_cnt_r + CNT_ONE;
            end
        end
    end

    assign cycle_cnt = cycle_cnt_r;
    assign instr_cnt = instr_cnt_r;
`endif

endmodule
